f1_start_ctrl: RTL and testbench
================================

# f1_start_ctrl

Sequencer for the F1 start-light bar. On a trigger edge it steps the eight lights on one per tick, holds all lights for a pseudo-random number of ticks, then switches them off and pulses `go`. It can also time the driver's reaction. It sits between the board inputs (trigger/react buttons) and the light-bar/display outputs, and owns its own tick divider and LFSR.

## Interface
Parameters:
- `TICK_CYCLES`, default 8: clk cycles per light tick; must be ≥ 2.
- `HOLD_MIN`, default 2: minimum all-lights-on hold, in ticks; must be ≥ 1.
- `LFSR_SEED`, default 7'h01: LFSR reset value; must be non-zero.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `trigger` in 1: start request. Only a rising edge is used.
- `react` in 1: driver button. Used only with the reaction-timer feature compiled in.
- `data_out` out 8: light bar. Light n on = `data_out[n-1]`.
- `busy` out 1: high in every state except IDLE.
- `go` out 1: one-cycle pulse on lights-out.
- `reaction_time` out 16: measured reaction, in clk cycles.
- `reaction_valid` out 1: one-cycle strobe qualifying `reaction_time`.

## Operation
- **Reset.** State is IDLE. `data_out`=0, `busy`=0, `go`=0, `reaction_time`=0, `reaction_valid`=0. LFSR=`LFSR_SEED`. Trigger history register=0, so a trigger held high through reset is accepted as an edge.
- **Trigger edge detect.** Accept when `trigger`=1, the previous sampled `trigger`=0, and state=IDLE. Edges in any other state are dropped, not queued.
- **LFSR.** 7-bit Fibonacci, free-running every cycle. Feedback = q[6]^q[2]; next q = {q[5:0], fb}.
- **IDLE.** `data_out`=0. On accept: go to LIGHTS, light count=0, tick divider cleared.
- **LIGHTS.** Each tick increments the light count n; `data_out` = (1<<n)-1.
  - On the tick that makes n=8, go to HOLD.
  - Load hold = `HOLD_MIN` + LFSR[3:0], using the LFSR value before that edge.
- **HOLD.** `data_out`=8'hFF. On each tick: if hold=1, go to OUT; else decrement hold.
- **OUT.** `data_out`=0. `go`=1 for the first cycle only.
  - Without the feature: OUT lasts one cycle, then IDLE.
- **Tick divider.** Counts 0..`TICK_CYCLES`-1; tick asserts when count=`TICK_CYCLES`-1, then wraps. Cleared synchronously on accept. Runs only in LIGHTS/HOLD.
- **Reset mid-operation.** Takes effect at the next edge from any state and discards any sequence in progress.

## Timing
- Accept at edge k:
  - `busy`=1 after edge k.
  - `data_out`=8'h01 after edge k+`TICK_CYCLES`.
  - Light n appears after edge k+n·`TICK_CYCLES`.
  - 8'hFF appears after edge k+8·`TICK_CYCLES`.
- Lights out (OUT entry, `go`=1) after edge k+(8+H)·`TICK_CYCLES`, where H ∈ [`HOLD_MIN`, `HOLD_MIN`+15].
- `reaction_valid` and `reaction_time` update on the same edge, then `reaction_valid` returns to 0 on the next edge.
- Earliest re-accept is the cycle after return to IDLE; a new rising edge is needed.

## Configuration
Macro `F1_REACTION_TIMER_EN`.

Defined:
- **OUT entry.** A 16-bit counter is cleared to 0.
- **Counting.** Each edge in OUT with `react`=0 increments the counter.
- **Capture.** At the edge where `react`=1, `reaction_time` = counter+1 and `reaction_valid` pulses. Go to IDLE. The earliest possible value is 1.
- **Timeout.** If the counter reaches 16'hFFFE with no react, report 16'hFFFF and go to IDLE.
- **Jump start.** `react`=1 sampled in LIGHTS or HOLD sets a jump flag. The sequence completes normally. At OUT entry (same edge that raises `go`), report 16'hFFFF and return to IDLE after one cycle.

Undefined:
- `react` is ignored; `reaction_time` and `reaction_valid` are tied to 0.

## Structure
- Package `f1_pkg`:
  - state enum `f1_ctrl_state_t` {IDLE, LIGHTS, HOLD, OUT}.
  - `F1_LIGHTS`=8.
  - `F1_REACT_INVALID`=16'hFFFF.
  - LFSR tap constants.
- Sub-module `f1_tick`: the parameterised tick divider with synchronous clear and enable, outputting a one-cycle `tick`.
- LFSR and FSM are inline in `f1_start_ctrl`.

## Test plan
All scenarios use `TICK_CYCLES`=4, `HOLD_MIN`=2, `F1_REACTION_TIMER_EN` defined.
1. Reset for 3 cycles → every output 0, `busy`=0; `trigger` held low for 50 cycles → `data_out` stays 0.
2. One-cycle trigger pulse at edge k → `data_out` is 01, 03, …, FF after edges k+4 … k+32. `go` pulses at edge k+4·(8+H), with H∈[2,17] matching a reference LFSR model.
3. Second trigger edge during LIGHTS, and `trigger` held high throughout a sequence → exactly one sequence runs; after IDLE, no restart until `trigger` falls and rises again.
4. `react` rises so it is first sampled high 10 edges after OUT entry → `reaction_time`=10, `reaction_valid` high for exactly one cycle, `busy`=0 next cycle.
5. `react` pulsed in HOLD → at lights-out, `reaction_time`=16'hFFFF with `reaction_valid`=1. Separately: no react for 65535 cycles → timeout report of 16'hFFFF.
6. `rst` asserted for one cycle in mid-HOLD → after that edge `data_out`=0, `busy`=0, no `go`. A new trigger then runs a full sequence from the start.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LIGHTS = 2'd1,
    HOLD   = 2'd2,
    OUT    = 2'd3
  } f1_ctrl_state_t;

  localparam int          F1_LIGHTS        = 8;
  localparam logic [15:0] F1_REACT_INVALID = 16'hFFFF;
  localparam logic [15:0] F1_REACT_LIMIT   = 16'hFFFE;

  localparam int F1_LFSR_W      = 7;
  localparam int F1_LFSR_TAP_HI = 6;
  localparam int F1_LFSR_TAP_LO = 2;

  // Thermometer code with the lowest n lights on.
  function automatic logic [7:0] f1_light_mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/f1_tick.sv
// Light-tick divider: one-cycle tick every TICK_CYCLES enabled clocks.
module f1_tick #(
  parameter int TICK_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer with optional reaction timer (F1_REACTION_TIMER_EN).
// Lights step on per tick, hold for a pseudo-random time, then go dark with a go pulse.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int         TICK_CYCLES = 8,
  parameter int         HOLD_MIN    = 2,
  parameter logic [6:0] LFSR_SEED   = 7'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic        react,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        go,
  output logic [15:0] reaction_time,
  output logic        reaction_valid
);

  localparam int HOLD_W = $clog2(HOLD_MIN + 16) + 1;

  f1_ctrl_state_t       state;
  logic [3:0]           light_cnt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [F1_LFSR_W-1:0] lfsr;
  logic                 trig_prev;
  logic                 accept;
  logic                 tick;
  logic                 tick_en;

`ifdef F1_REACTION_TIMER_EN
  logic        jump;
  logic [15:0] react_cnt;
`else
  logic unused_react;
  assign unused_react   = react;
  assign reaction_time  = '0;
  assign reaction_valid = 1'b0;
`endif

  assign accept  = trigger && !trig_prev && (state == IDLE);
  assign tick_en = (state == LIGHTS) || (state == HOLD);

  f1_tick #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (tick_en),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      light_cnt <= '0;
      hold_cnt  <= '0;
      lfsr      <= LFSR_SEED;
      trig_prev <= 1'b0;
      go        <= 1'b0;
`ifdef F1_REACTION_TIMER_EN
      jump           <= 1'b0;
      react_cnt      <= '0;
      reaction_time  <= '0;
      reaction_valid <= 1'b0;
`endif
    end else begin
      lfsr      <= {lfsr[F1_LFSR_W-2:0], lfsr[F1_LFSR_TAP_HI] ^ lfsr[F1_LFSR_TAP_LO]};
      trig_prev <= trigger;
      go        <= 1'b0;
`ifdef F1_REACTION_TIMER_EN
      reaction_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= LIGHTS;
            light_cnt <= '0;
`ifdef F1_REACTION_TIMER_EN
            jump      <= 1'b0;
`endif
          end
        end
        LIGHTS: begin
`ifdef F1_REACTION_TIMER_EN
          if (react) jump <= 1'b1;
`endif
          if (tick) begin
            light_cnt <= light_cnt + 4'd1;
            if (light_cnt == 4'(F1_LIGHTS - 1)) begin
              state    <= HOLD;
              hold_cnt <= HOLD_W'(HOLD_MIN) + HOLD_W'(lfsr[3:0]);
            end
          end
        end
        HOLD: begin
`ifdef F1_REACTION_TIMER_EN
          if (react) jump <= 1'b1;
`endif
          if (tick) begin
            if (hold_cnt == HOLD_W'(1)) begin
              state <= OUT;
              go    <= 1'b1;
`ifdef F1_REACTION_TIMER_EN
              react_cnt <= '0;
              // A press sampled on this very edge still counts as a jump start.
              if (jump || react) begin
                reaction_time  <= F1_REACT_INVALID;
                reaction_valid <= 1'b1;
              end
`endif
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end
          end
        end
        OUT: begin
`ifdef F1_REACTION_TIMER_EN
          if (jump) begin
            state <= IDLE;
            jump  <= 1'b0;
          end else if (react) begin
            state          <= IDLE;
            reaction_time  <= react_cnt + 16'd1;
            reaction_valid <= 1'b1;
          end else if (react_cnt == F1_REACT_LIMIT) begin
            state          <= IDLE;
            reaction_time  <= F1_REACT_INVALID;
            reaction_valid <= 1'b1;
          end else begin
            react_cnt <= react_cnt + 16'd1;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    case (state)
      LIGHTS:  data_out = f1_light_mask(light_cnt);
      HOLD:    data_out = 8'hFF;
      default: data_out = '0;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Self-checking bench for f1_start_ctrl: table vectors, random sequences, corner cases.
module tb_f1_start_ctrl;

  localparam int         TC   = 4;
  localparam int         HMIN = 2;
  localparam logic [6:0] SEED = 7'h01;

  localparam int R_REACT = 0;
  localparam int R_JUMP  = 1;
  localparam int R_NONE  = 2;

`ifdef F1_REACTION_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  typedef struct {
    int          trig_mode;  // 0 pulse, 1 pulse plus retrigger in LIGHTS, 2 held high
    int          rmode;
    int          rarg;
    logic [15:0] exp_rt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        react;
  logic [7:0]  data_out;
  logic        busy;
  logic        go;
  logic [15:0] reaction_time;
  logic        reaction_valid;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0]  m_lfsr;
  logic [15:0] last_rt;
  vec_t        tbl[7];

  always #5 clk = ~clk;

  f1_start_ctrl #(
    .TICK_CYCLES(TC),
    .HOLD_MIN   (HMIN),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trigger       (trigger),
    .react         (react),
    .data_out      (data_out),
    .busy          (busy),
    .go            (go),
    .reaction_time (reaction_time),
    .reaction_valid(reaction_valid)
  );

  // Reference LFSR: free-running 7-bit Fibonacci, taps 6 and 2.
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] pack(input logic [7:0] d, input logic b, input logic g,
                                       input logic v, input logic [15:0] rt);
    return {d, b, g, v, rt};
  endfunction

  task automatic chk(input string name, input int t, input logic [26:0] exp);
    logic [26:0] act;
    act = {data_out, busy, go, reaction_valid, reaction_time};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d got {data,busy,go,vld,rt}=%h expected %h", name, t, act, exp);
    end
  endtask

  // One full sequence from the trigger edge; t counts edges after the accept edge.
  task automatic run_seq(input string name, input int trig_mode, input int rmode,
                         input int rarg, input logic [15:0] exp_rt);
    int          t;
    int          h;
    int          t_out;
    int          t_end;
    int          t_rep;
    int          m;
    logic [7:0]  e_data;
    logic        e_vld;
    t_out = 1 << 30;
    t_end = 1 << 30;
    t_rep = -1;
    trigger = 1'b1;
    step();
    t = 0;
    if (trig_mode != 2) trigger = 1'b0;
    while (t <= t_end + 1) begin
      if (t == 8 * TC - 1) begin
        h     = HMIN + int'(m_lfsr[3:0]);
        t_out = (8 + h) * TC;
        if (!TIMER)                 begin t_end = t_out + 1;     t_rep = -1;    end
        else if (rmode == R_JUMP)   begin t_end = t_out + 1;     t_rep = t_out; end
        else if (rmode == R_REACT)  begin t_end = t_out + rarg;  t_rep = t_end; end
        else                        begin t_end = t_out + 65535; t_rep = t_end; end
      end
      if (t < 8 * TC) begin
        m      = (1 << (t / TC)) - 1;
        e_data = m[7:0];
      end else if (t < t_out) begin
        e_data = 8'hFF;
      end else begin
        e_data = 8'h00;
      end
      e_vld = (t == t_rep);
      if (e_vld) last_rt = exp_rt;
      chk(name, t, pack(e_data, t < t_end, t == t_out, e_vld, last_rt));
      if (rmode == R_REACT)     react = (t == t_out + rarg - 1);
      else if (rmode == R_JUMP) react = (t == rarg);
      else                      react = 1'b0;
      if (trig_mode == 1) trigger = (t == 6);
      step();
      t++;
    end
    react = 1'b0;
    if (trig_mode == 2) begin
      for (int i = 0; i < 10; i++) begin
        step();
        chk({name, "_held_no_restart"}, i, pack(8'h00, 1'b0, 1'b0, 1'b0, last_rt));
      end
      trigger = 1'b0;
      step();
    end
  endtask

  initial begin
    tbl[0] = '{0, R_REACT, 10, 16'd10};
    tbl[1] = '{0, R_REACT, 1,  16'd1};
    tbl[2] = '{0, R_REACT, 3,  16'd3};
    tbl[3] = '{1, R_REACT, 5,  16'd5};
    tbl[4] = '{0, R_JUMP,  5,  16'hFFFF};
    tbl[5] = '{0, R_JUMP,  34, 16'hFFFF};
    tbl[6] = '{2, R_REACT, 2,  16'd2};

    rst     = 1'b1;
    trigger = 1'b0;
    react   = 1'b0;
    last_rt = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset", i, pack(8'h00, 1'b0, 1'b0, 1'b0, 16'h0000));
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_no_trigger", i, pack(8'h00, 1'b0, 1'b0, 1'b0, 16'h0000));
    end

    for (int i = 0; i < 7; i++) begin
      run_seq($sformatf("table%0d", i), tbl[i].trig_mode, tbl[i].rmode, tbl[i].rarg,
              tbl[i].exp_rt);
    end

    for (int i = 0; i < 12; i++) begin
      int gap;
      int rm;
      int ra;
      int tm;
      gap = $urandom_range(1, 6);
      for (int g = 0; g < gap; g++) step();
      rm = $urandom_range(0, 1);
      tm = $urandom_range(0, 1);
      ra = (rm == R_REACT) ? $urandom_range(1, 40) : $urandom_range(0, 10 * TC - 1);
      run_seq($sformatf("rand%0d", i), tm, rm, ra,
              (rm == R_REACT) ? 16'(ra) : 16'hFFFF);
    end

    run_seq("timeout", 0, R_NONE, 0, 16'hFFFF);

    // Reset during HOLD discards the sequence.
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 0; i < 8 * TC + 2; i++) step();
    chk("pre_rst_hold", 0, pack(8'hFF, 1'b1, 1'b0, 1'b0, last_rt));
    rst = 1'b1;
    step();
    last_rt = 16'h0000;
    chk("midhold_rst", 0, pack(8'h00, 1'b0, 1'b0, 1'b0, 16'h0000));
    rst = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      chk("after_rst_idle", i, pack(8'h00, 1'b0, 1'b0, 1'b0, 16'h0000));
    end
    run_seq("after_rst_seq", 0, R_REACT, 7, 16'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
